// File: rtl/ntt_stage_sequencer.sv
// Address/strobe sequencer for an in-place radix-2 NTT: walks every stage and
// butterfly, then drains the butterfly pipeline. The optional inverse (Gentleman-Sande)
// ordering is enabled with the OPEN_NTT_INVERSE_EN macro.
module ntt_stage_sequencer #(
    parameter int LOGN = 10,
    parameter int LAT  = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start_i,
`ifdef OPEN_NTT_INVERSE_EN
    input  logic                                       inv_i,
`endif
    input  logic                                       hold_i,
    output logic                                       busy_o,
    output logic                                       done_o,
    output logic                                       rd_en_o,
    output logic [LOGN-1:0]                            rd_addr_a_o,
    output logic [LOGN-1:0]                            rd_addr_b_o,
`ifdef OPEN_NTT_INVERSE_EN
    output logic [LOGN:0]                              tw_addr_o,
`else
    output logic [LOGN-1:0]                            tw_addr_o,
`endif
    output logic                                       wr_en_o,
    output logic [LOGN-1:0]                            wr_addr_a_o,
    output logic [LOGN-1:0]                            wr_addr_b_o,
    output logic [((LOGN > 1) ? $clog2(LOGN) : 1)-1:0] stage_o
);

    localparam int N_HALF = 1 << (LOGN - 1);
    localparam int KW     = (LOGN > 1) ? LOGN - 1 : 1;
    localparam int SW     = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam int DW     = (LAT > 1) ? $clog2(LAT) : 1;
`ifdef OPEN_NTT_INVERSE_EN
    localparam int TWW    = LOGN + 1;
`else
    localparam int TWW    = LOGN;
`endif

    localparam logic [KW-1:0] K_LAST = KW'(N_HALF - 1);
    localparam logic [DW-1:0] D_LAST = DW'(LAT - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t          state, state_n;
    logic [KW-1:0]   k, k_n;
    logic [SW-1:0]   stage, stage_n;
    logic [DW-1:0]   dcnt, dcnt_n;
    logic            issue;

    logic [LOGN-1:0] k_ext, half, grp, offs, addr_a, addr_b, tw_lo;
    logic [SW-1:0]   sh, sh_c;
    logic [TWW-1:0]  tw;

    logic            d_en [LAT];
    logic [LOGN-1:0] d_a  [LAT];
    logic [LOGN-1:0] d_b  [LAT];

`ifdef OPEN_NTT_INVERSE_EN
    logic            inv_q;
`endif

    assign busy_o  = (state != IDLE);
    assign stage_o = stage;

    always_comb begin
        state_n = state;
        k_n     = k;
        stage_n = stage;
        dcnt_n  = dcnt;
        issue   = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_n = RUN;
                    k_n     = '0;
                    stage_n = '0;
                    dcnt_n  = '0;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (k == K_LAST) begin
                    state_n = DRAIN;
                    k_n     = '0;
                    dcnt_n  = '0;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            DRAIN: begin
                if (dcnt == D_LAST) begin
                    dcnt_n = '0;
                    if (stage == S_LAST) begin
                        state_n = DONE;
                    end else begin
                        state_n = RUN;
                        stage_n = stage + 1'b1;
                    end
                end else begin
                    dcnt_n = dcnt + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // sh is log2 of the butterfly span; the twiddle base uses the complementary shift
    always_comb begin
        k_ext = LOGN'(k);
`ifdef OPEN_NTT_INVERSE_EN
        sh    = inv_q ? stage : (S_LAST - stage);
`else
        sh    = S_LAST - stage;
`endif
        sh_c   = S_LAST - sh;
        half   = LOGN'(1) << sh;
        grp    = k_ext >> sh;
        offs   = k_ext & (half - LOGN'(1));
        addr_a = ((grp << sh) << 1) | offs;
        addr_b = addr_a + half;
        tw_lo  = (LOGN'(1) << sh_c) + grp;
`ifdef OPEN_NTT_INVERSE_EN
        tw     = {inv_q, tw_lo};
`else
        tw     = tw_lo;
`endif
    end

    // A held cycle freezes all state, including the write delay line, and blanks the strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            stage       <= '0;
            dcnt        <= '0;
            rd_en_o     <= 1'b0;
            rd_addr_a_o <= '0;
            rd_addr_b_o <= '0;
            tw_addr_o   <= '0;
            wr_en_o     <= 1'b0;
            wr_addr_a_o <= '0;
            wr_addr_b_o <= '0;
            done_o      <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                d_en[i] <= 1'b0;
                d_a[i]  <= '0;
                d_b[i]  <= '0;
            end
`ifdef OPEN_NTT_INVERSE_EN
            inv_q       <= 1'b0;
`endif
        end else if (hold_i) begin
            rd_en_o <= 1'b0;
            wr_en_o <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            state   <= state_n;
            k       <= k_n;
            stage   <= stage_n;
            dcnt    <= dcnt_n;
            rd_en_o <= issue;
            done_o  <= (state == DONE);
`ifdef OPEN_NTT_INVERSE_EN
            if (state == IDLE && start_i) begin
                inv_q <= inv_i;
            end
`endif
            if (issue) begin
                rd_addr_a_o <= addr_a;
                rd_addr_b_o <= addr_b;
                tw_addr_o   <= tw;
            end
            d_en[0] <= issue;
            d_a[0]  <= addr_a;
            d_b[0]  <= addr_b;
            for (int i = 1; i < LAT; i++) begin
                d_en[i] <= d_en[i-1];
                d_a[i]  <= d_a[i-1];
                d_b[i]  <= d_b[i-1];
            end
            wr_en_o     <= d_en[LAT-1];
            wr_addr_a_o <= d_a[LAT-1];
            wr_addr_b_o <= d_b[LAT-1];
        end
    end

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Self-checking bench for ntt_stage_sequencer (LOGN=3, LAT=2) against a schedule-based
// reference model; inverse ordering is exercised when OPEN_NTT_INVERSE_EN is defined.
module tb_ntt_stage_sequencer;

    localparam int LOGN  = 3;
    localparam int LAT   = 2;
    localparam int N     = 1 << LOGN;
    localparam int SW    = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam int TOTAL = LOGN * (N / 2 + LAT) + 1;
`ifdef OPEN_NTT_INVERSE_EN
    localparam int TWW   = LOGN + 1;
`else
    localparam int TWW   = LOGN;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic            hold_i;
    logic            inv_i;
    logic            busy_o, done_o, rd_en_o, wr_en_o;
    logic [LOGN-1:0] rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
    logic [TWW-1:0]  tw_addr_o;
    logic [SW-1:0]   stage_o;

    ntt_stage_sequencer #(.LOGN(LOGN), .LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
`ifdef OPEN_NTT_INVERSE_EN
        .inv_i       (inv_i),
`endif
        .hold_i      (hold_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rd_en_o     (rd_en_o),
        .rd_addr_a_o (rd_addr_a_o),
        .rd_addr_b_o (rd_addr_b_o),
        .tw_addr_o   (tw_addr_o),
        .wr_en_o     (wr_en_o),
        .wr_addr_a_o (wr_addr_a_o),
        .wr_addr_b_o (wr_addr_b_o),
        .stage_o     (stage_o)
    );

    always #5 clk = ~clk;

    // One entry per non-held clock edge of a transform
    typedef struct {
        bit rd;
        bit done;
        int a;
        int b;
        int tw;
        int stage;
    } item_t;

    typedef struct {
        int due;
        int a;
        int b;
    } wr_t;

    item_t sched[$];
    wr_t   wq[$];
    bit    active;
    int    nh;
    bit    e_rd, e_wr, e_done;
    int    e_stage, e_a, e_b, e_tw, e_wa, e_wb;
    int    errors, checks;
    int    done_seen, done_edge, cur_edge;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s edge=%0d observed=%0h expected=%0h", tag, cur_edge, obs, exp);
        end
    endtask

    task automatic buildSchedule(input bit inv);
        item_t it;
        int half, g, j;
        sched.delete();
        for (int s = 0; s < LOGN; s++) begin
            for (int k = 0; k < N / 2; k++) begin
                if (inv) half = 1 << s;
                else     half = 1 << (LOGN - 1 - s);
                g = k / half;
                j = k % half;
                it.rd    = 1'b1;
                it.done  = 1'b0;
                it.a     = 2 * half * g + j;
                it.b     = it.a + half;
                it.tw    = inv ? (N + (1 << (LOGN - 1 - s)) + g) : ((1 << s) + g);
                it.stage = s;
                sched.push_back(it);
            end
            for (int d = 0; d < LAT; d++) begin
                it.rd    = 1'b0;
                it.done  = 1'b0;
                it.a     = 0;
                it.b     = 0;
                it.tw    = 0;
                it.stage = (d == LAT - 1 && s < LOGN - 1) ? s + 1 : s;
                sched.push_back(it);
            end
        end
        it.rd    = 1'b0;
        it.done  = 1'b1;
        it.stage = LOGN - 1;
        sched.push_back(it);
    endtask

    // Drive one cycle of inputs, advance the model by one edge and compare
    task automatic applyStimulus(input bit r, input bit s, input bit h, input bit inv);
        item_t it;
        wr_t   w;
        rst     = r;
        start_i = s;
        hold_i  = h;
        inv_i   = inv;
        @(posedge clk);
        #1;
        e_rd   = 1'b0;
        e_wr   = 1'b0;
        e_done = 1'b0;
        if (r) begin
            sched.delete();
            wq.delete();
            active  = 1'b0;
            e_stage = 0;
        end else if (!h) begin
            nh++;
            if (active && sched.size() > 0) begin
                it      = sched.pop_front();
                e_rd    = it.rd;
                e_done  = it.done;
                e_stage = it.stage;
                e_a     = it.a;
                e_b     = it.b;
                e_tw    = it.tw;
                if (it.rd) wq.push_back('{due: nh + LAT, a: it.a, b: it.b});
                if (it.done) active = 1'b0;
            end else if (!active && s) begin
`ifdef OPEN_NTT_INVERSE_EN
                buildSchedule(inv);
`else
                buildSchedule(1'b0);
`endif
                active  = 1'b1;
                e_stage = 0;
            end
            if (wq.size() > 0 && wq[0].due == nh) begin
                w    = wq.pop_front();
                e_wr = 1'b1;
                e_wa = w.a;
                e_wb = w.b;
            end
        end
        checkOutput("busy", 32'(busy_o), 32'(active));
        checkOutput("rd_en", 32'(rd_en_o), 32'(e_rd));
        checkOutput("wr_en", 32'(wr_en_o), 32'(e_wr));
        checkOutput("done", 32'(done_o), 32'(e_done));
        checkOutput("stage", 32'(stage_o), e_stage);
        if (e_rd) begin
            checkOutput("rd_addr_a", 32'(rd_addr_a_o), e_a);
            checkOutput("rd_addr_b", 32'(rd_addr_b_o), e_b);
            checkOutput("tw_addr", 32'(tw_addr_o), e_tw);
        end
        if (e_wr) begin
            checkOutput("wr_addr_a", 32'(wr_addr_a_o), e_wa);
            checkOutput("wr_addr_b", 32'(wr_addr_b_o), e_wb);
        end
        if (done_o === 1'b1) begin
            done_seen++;
            done_edge = cur_edge;
        end
    endtask

    task automatic runTransform(input bit inv, input int hold_pct, input int start_pct,
                                input int hold_at, input int hold_len, input int rst_at);
        int held;
        bit h;
        bit aborted;
        done_seen = 0;
        done_edge = -1;
        cur_edge  = 0;
        held      = 0;
        aborted   = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, inv);
        for (int c = 1; c < 300 && active; c++) begin
            cur_edge = c;
            if (c == rst_at) begin
                applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
                aborted = 1'b1;
            end else begin
                h = (c >= hold_at && c < hold_at + hold_len) ||
                    (int'($urandom_range(99)) < hold_pct);
                if (h) held++;
                applyStimulus(1'b0, int'($urandom_range(99)) < start_pct, h, 1'($urandom_range(1)));
            end
        end
        for (int c = 0; c < 3; c++) begin
            cur_edge++;
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end
        if (aborted) begin
            checkOutput("abort_done_count", done_seen, 0);
        end else begin
            checkOutput("done_count", done_seen, 1);
            checkOutput("done_latency", done_edge, TOTAL + held);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        active   = 1'b0;
        nh       = 0;
        e_stage  = 0;
        cur_edge = 0;
        rst      = 1'b1;
        start_i  = 1'b0;
        hold_i   = 1'b0;
        inv_i    = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] plain forward transform");
        runTransform(1'b0, 0, 0, 0, 0, 0);
        $display("[TB] three held cycles in stage 1");
        runTransform(1'b0, 0, 0, 8, 3, 0);
        $display("[TB] start held high while busy");
        runTransform(1'b0, 0, 100, 0, 0, 0);
        $display("[TB] reset at edge 8, then a fresh transform");
        runTransform(1'b0, 0, 0, 0, 0, 8);
        runTransform(1'b0, 0, 0, 0, 0, 0);
`ifdef OPEN_NTT_INVERSE_EN
        $display("[TB] inverse transform");
        runTransform(1'b1, 0, 0, 0, 0, 0);
`endif
        $display("[TB] randomized holds and start pulses");
        for (int t = 0; t < 6; t++) begin
            runTransform(1'($urandom_range(1)), 25, 20, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
